// File: rtl/reg_file_pkg.sv
// Shared integer-datapath constants and types for the register file and ALU.
package reg_file_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   xword_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/rf_read_port.sv
// One combinational register-file read port: address decode, x0 force-to-zero
// and an optional write-first bypass selected by the BYPASS parameter.
module rf_read_port
  import reg_file_pkg::*;
#(
  parameter int unsigned n      = XLEN,
  parameter int unsigned NREG   = NUM_REGS,
  parameter int unsigned AW     = REG_AW,
  parameter bit          BYPASS = 1'b0
) (
  input  logic                     rst_n,
  input  logic [NREG-1:0][n-1:0]   regs_i,
  input  logic [AW-1:0]            addr_i,
  input  logic                     wr_en_i,
  input  logic [AW-1:0]            wr_addr_i,
  input  logic [n-1:0]             wr_data_i,
  output logic [n-1:0]             data_o
);

  logic hit_c;

  generate
    if (BYPASS) begin : g_bypass
      assign hit_c = wr_en_i && (wr_addr_i != AW'(REG_ZERO)) && (wr_addr_i == addr_i);
    end else begin : g_no_bypass
      logic unused_wr;
      assign unused_wr = ^{wr_en_i, wr_addr_i, wr_data_i};
      assign hit_c     = 1'b0;
    end
  endgenerate

  // Reset and x0 both force zero; bypass data never leaks out during reset.
  always_comb begin
    data_o = '0;
    if (rst_n && (addr_i != AW'(REG_ZERO))) begin
      data_o = hit_c ? wr_data_i : regs_i[addr_i];
    end
  end

endmodule

// File: rtl/reg_file.sv
// Integer register file: x1..x(NREG-1) stored, x0 reads zero, two operand read
// ports plus an unbypassed debug port. Define RF_BYPASS_EN for write-first reads.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int unsigned n    = XLEN,
  parameter int unsigned NREG = NUM_REGS,
  parameter int unsigned AW   = REG_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  input  logic [AW-1:0] rd_addr,
  input  logic [n-1:0]  rd_data,
  input  logic          reg_write,
  output logic [n-1:0]  rs1_data,
  output logic [n-1:0]  rs2_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [n-1:0]  dbg_data
);

`ifdef RF_BYPASS_EN
  localparam bit RdBypass = 1'b1;
`else
  localparam bit RdBypass = 1'b0;
`endif

  logic [NREG-1:1][n-1:0] regs_q;
  logic [NREG-1:1][n-1:0] regs_d;
  logic [NREG-1:0][n-1:0] rf_view;

  // Write decode; address 0 matches no physical register, so x0 writes drop.
  always_comb begin
    regs_d = regs_q;
    for (int unsigned i = 1; i < NREG; i++) begin
      if (reg_write && (rd_addr == AW'(i))) begin
        regs_d[i] = rd_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rf_view = {regs_q, n'(0)};

  rf_read_port #(.n(n), .NREG(NREG), .AW(AW), .BYPASS(RdBypass)) u_rs1 (
    .rst_n     (rst_n),
    .regs_i    (rf_view),
    .addr_i    (rs1_addr),
    .wr_en_i   (reg_write),
    .wr_addr_i (rd_addr),
    .wr_data_i (rd_data),
    .data_o    (rs1_data)
  );

  rf_read_port #(.n(n), .NREG(NREG), .AW(AW), .BYPASS(RdBypass)) u_rs2 (
    .rst_n     (rst_n),
    .regs_i    (rf_view),
    .addr_i    (rs2_addr),
    .wr_en_i   (reg_write),
    .wr_addr_i (rd_addr),
    .wr_data_i (rd_data),
    .data_o    (rs2_data)
  );

  // Debug port always shows committed state.
  rf_read_port #(.n(n), .NREG(NREG), .AW(AW), .BYPASS(1'b0)) u_dbg (
    .rst_n     (rst_n),
    .regs_i    (rf_view),
    .addr_i    (dbg_addr),
    .wr_en_i   (reg_write),
    .wr_addr_i (rd_addr),
    .wr_data_i (rd_data),
    .data_o    (dbg_data)
  );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table, reset corner
// sequences and randomized traffic against an array-based reference model.
module tb_reg_file;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr, dbg_addr;
  logic [31:0] rd_data;
  logic        reg_write;
  logic [31:0] rs1_data, rs2_data, dbg_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] model [32];

  reg_file dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .reg_write (reg_write),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  ad;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] ed;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
    reg_write = we;
    rd_addr   = rd;
    rd_data   = wd;
    rs1_addr  = a1;
    rs2_addr  = a2;
    dbg_addr  = ad;
  endtask

  // Reference read: x0 is zero, optional write-first forwarding, else stored value.
  function automatic logic [31:0] ref_read(input logic [4:0] a, input logic can_bypass);
    if (a == 5'd0) return 32'h0;
    if (can_bypass && BYP && reg_write && rd_addr == a) return rd_data;
    return model[a];
  endfunction

  initial begin
    vecs[0]  = '{1'b1, 5'd1,  32'h7,        5'd1,  5'd0,  5'd1,  BYP ? 32'h7 : 32'h0, 32'h0, 32'h0};
    vecs[1]  = '{1'b1, 5'd31, 32'h80000000, 5'd1,  5'd31, 5'd31, 32'h7, BYP ? 32'h80000000 : 32'h0, 32'h0};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        5'd1,  5'd31, 5'd31, 32'h7, 32'h80000000, 32'h80000000};
    vecs[3]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  5'd0,  32'h0, 32'h0, 32'h0};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  5'd0,  32'h0, 32'h0, 32'h0};
    vecs[5]  = '{1'b1, 5'd10, 32'h11,       5'd10, 5'd10, 5'd10, BYP ? 32'h11 : 32'h0, BYP ? 32'h11 : 32'h0, 32'h0};
    vecs[6]  = '{1'b1, 5'd10, 32'h22,       5'd10, 5'd1,  5'd10, BYP ? 32'h22 : 32'h11, 32'h7, 32'h11};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,        5'd10, 5'd10, 5'd10, 32'h22, 32'h22, 32'h22};
    vecs[8]  = '{1'b1, 5'd3,  32'h5,        5'd3,  5'd31, 5'd3,  BYP ? 32'h5 : 32'h0, 32'h80000000, 32'h0};
    vecs[9]  = '{1'b0, 5'd3,  32'hABCD,     5'd3,  5'd3,  5'd3,  32'h5, 32'h5, 32'h5};
    vecs[10] = '{1'b0, 5'd3,  32'hABCD,     5'd3,  5'd0,  5'd3,  32'h5, 32'h0, 32'h5};
    vecs[11] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  5'd5,  BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 32'h0};

    // Reset held with a live write request: everything reads zero.
    rst_n = 1'b0;
    drive(1'b1, 5'd4, 32'h9, 5'd4, 5'd4, 5'd4);
    #7;
    chk("reset_rs1", rs1_data, 32'h0);
    chk("reset_rs2", rs2_data, 32'h0);
    chk("reset_dbg", dbg_data, 32'h0);
    reg_write = 1'b0;
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].we, vecs[i].rd, vecs[i].wd, vecs[i].a1, vecs[i].a2, vecs[i].ad);
      #3;
      chk($sformatf("vec%0d_rs1", i), rs1_data, vecs[i].e1);
      chk($sformatf("vec%0d_rs2", i), rs2_data, vecs[i].e2);
      chk($sformatf("vec%0d_dbg", i), dbg_data, vecs[i].ed);
      @(posedge clk); #1;
    end

    // Asynchronous clear: x5 drops to zero before any clock edge.
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5);
    #2;
    chk("pre_clear_x5", rs1_data, 32'hDEADBEEF);
    #1 rst_n = 1'b0;
    #1;
    chk("async_clear_rs1", rs1_data, 32'h0);
    chk("async_clear_rs2", rs2_data, 32'h0);
    chk("async_clear_dbg", dbg_data, 32'h0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_clear_x5", dbg_data, 32'h0);

    // Reset asserted in a write cycle discards the write to x4.
    drive(1'b1, 5'd4, 32'h9, 5'd4, 5'd4, 5'd4);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_write_nobyp", rs1_data, 32'h0);
    @(posedge clk); #2;
    reg_write = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rst_write_x4_rs1", rs1_data, 32'h0);
    @(posedge clk); #1;
    chk("rst_write_x4_next", rs1_data, 32'h0);
    chk("rst_write_x4_dbg", dbg_data, 32'h0);

    // Randomized traffic against the reference model.
    for (int r = 0; r < 32; r++) model[r] = 32'h0;
    for (int it = 0; it < 400; it++) begin
      logic [4:0] rd;
      rd = 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), rd, $urandom,
            ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31)));
      #3;
      chk($sformatf("rand%0d_rs1", it), rs1_data, ref_read(rs1_addr, 1'b1));
      chk($sformatf("rand%0d_rs2", it), rs2_data, ref_read(rs2_addr, 1'b1));
      chk($sformatf("rand%0d_dbg", it), dbg_data, ref_read(dbg_addr, 1'b0));
      @(posedge clk); #1;
      if (reg_write && rd_addr != 5'd0) model[rd_addr] = rd_data;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
